// File: rtl/rr_output_arbiter.sv
// Round-robin output-port arbiter: grants one requester whose next hop matches
// PORT_ADDR and holds that grant from the head flit through the tail flit.
module rr_output_arbiter #(
  parameter int                NUM_REQ   = 5,
  parameter int                ADDR_W    = 3,
  parameter logic [ADDR_W-1:0] PORT_ADDR = ADDR_W'(2),
  parameter int                SELF_IDX  = 2,
  parameter int                IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_nexthop_addr_i,
  input  logic [NUM_REQ-1:0]        req_tail_i,
  input  logic                      out_ready_i,
  output logic                      grant_valid_o,
  output logic [NUM_REQ-1:0]        grant_onehot_o,
  output logic [IDX_W-1:0]          grant_idx_o,
  output logic [IDX_W-1:0]          rr_ptr_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic                 grant_valid_reg, grant_valid_next;
  logic [IDX_W-1:0]     grant_idx_reg, grant_idx_next;
  logic [NUM_REQ-1:0]   grant_onehot_reg, grant_onehot_next;

  logic [NUM_REQ-1:0]   desire;
  logic [IDX_W-1:0]     ptr_after_owner;
  logic                 owner_valid;
  logic                 owner_tail;
  logic                 release_pkt;
  logic [IDX_W-1:0]     scan_start;
  logic [NUM_REQ-1:0]   scan_mask;
  int                   scan_pos;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]   win_onehot;

  // The U-turn input is removed from the candidate set at elaboration time.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_desire
      if (gi == SELF_IDX) begin : g_self
        assign desire[gi] = 1'b0;
      end else begin : g_peer
        assign desire[gi] = req_valid_i[gi] &&
                            (req_nexthop_addr_i[gi*ADDR_W +: ADDR_W] == PORT_ADDR);
      end
    end
  endgenerate

  assign owner_valid     = |(req_valid_i & grant_onehot_reg);
  assign owner_tail      = |(req_tail_i & grant_onehot_reg);
  assign release_pkt     = (state_reg == LOCKED) && owner_valid && out_ready_i && owner_tail;
  assign ptr_after_owner = (grant_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : grant_idx_reg + 1'b1;

  // One scanner serves both fresh arbitration from rr_ptr and the
  // back-to-back re-arbitration at release, which excludes the old owner.
  always_comb begin
    scan_start = rr_ptr_reg;
    scan_mask  = desire;
    if (state_reg == LOCKED) begin
      scan_start = ptr_after_owner;
      scan_mask  = desire & ~grant_onehot_reg;
    end
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    scan_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_pos = int'(scan_start) + k;
      if (scan_pos >= NUM_REQ) begin
        scan_pos = scan_pos - NUM_REQ;
      end
      if (!win_found && scan_mask[scan_pos]) begin
        win_found            = 1'b1;
        win_idx              = IDX_W'(scan_pos);
        win_onehot           = '0;
        win_onehot[scan_pos] = 1'b1;
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    rr_ptr_next       = rr_ptr_reg;
    grant_valid_next  = grant_valid_reg;
    grant_idx_next    = grant_idx_reg;
    grant_onehot_next = grant_onehot_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next        = LOCKED;
          grant_valid_next  = 1'b1;
          grant_idx_next    = win_idx;
          grant_onehot_next = win_onehot;
        end
      end
      LOCKED: begin
        if (release_pkt) begin
          rr_ptr_next = ptr_after_owner;
          if (win_found) begin
            grant_idx_next    = win_idx;
            grant_onehot_next = win_onehot;
          end else begin
            state_next        = IDLE;
            grant_valid_next  = 1'b0;
            grant_idx_next    = '0;
            grant_onehot_next = '0;
          end
        end
      end
      default: begin
        state_next        = IDLE;
        grant_valid_next  = 1'b0;
        grant_idx_next    = '0;
        grant_onehot_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      rr_ptr_reg       <= '0;
      grant_valid_reg  <= 1'b0;
      grant_idx_reg    <= '0;
      grant_onehot_reg <= '0;
    end else begin
      state_reg        <= state_next;
      rr_ptr_reg       <= rr_ptr_next;
      grant_valid_reg  <= grant_valid_next;
      grant_idx_reg    <= grant_idx_next;
      grant_onehot_reg <= grant_onehot_next;
    end
  end

  assign grant_valid_o  = grant_valid_reg;
  assign grant_idx_o    = grant_idx_reg;
  assign grant_onehot_o = grant_onehot_reg;
  assign rr_ptr_o       = rr_ptr_reg;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Bench for rr_output_arbiter: vector table, directed multi-cycle sequences,
// a 3-input wrap instance, and random traffic against a packet-level model.
module tb_rr_output_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [4:0]  req_valid = '0;
  logic [14:0] req_addr = '0;
  logic [4:0]  req_tail = '0;
  logic        out_ready = 1'b0;
  logic        gv;
  logic [4:0]  oh;
  logic [2:0]  idx;
  logic [2:0]  ptr;

  logic [2:0]  v3 = '0;
  logic [8:0]  a3 = '0;
  logic [2:0]  t3 = '0;
  logic        r3 = 1'b0;
  logic        gv3;
  logic [2:0]  oh3;
  logic [1:0]  idx3;
  logic [1:0]  ptr3;

  int total = 0;
  int bad = 0;

  localparam logic [14:0] A2    = {5{3'd2}};
  localparam logic [14:0] A_MIX = {3'd3, 3'd2, 3'd2, 3'd2, 3'd2};

  rr_output_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_nexthop_addr_i(req_addr), .req_tail_i(req_tail),
    .out_ready_i(out_ready),
    .grant_valid_o(gv), .grant_onehot_o(oh), .grant_idx_o(idx), .rr_ptr_o(ptr)
  );

  rr_output_arbiter #(.NUM_REQ(3), .SELF_IDX(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid_i(v3), .req_nexthop_addr_i(a3), .req_tail_i(t3),
    .out_ready_i(r3),
    .grant_valid_o(gv3), .grant_onehot_o(oh3), .grant_idx_o(idx3), .rr_ptr_o(ptr3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  valid;
    logic [14:0] addr;
    logic [4:0]  tail;
    logic        ready;
    logic        exp_gv;
    logic [2:0]  exp_idx;
    logic [2:0]  exp_ptr;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected grant state as {valid, onehot, idx, ptr} for the 5-input instance.
  function automatic logic [31:0] pack5(input logic v, input logic [2:0] i, input logic [2:0] p);
    logic [4:0] o;
    o = '0;
    if (v) o[i] = 1'b1;
    return {20'd0, v, o, i, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0; req_addr = '0; req_tail = '0; out_ready = 1'b0;
    v3 = '0; a3 = '0; t3 = '0; r3 = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic drive(input logic [4:0] v, input logic [14:0] a, input logic [4:0] t, input logic r);
    req_valid = v; req_addr = a; req_tail = t; out_ready = r;
  endtask

  // Model: the winner is the desiring input closest (cyclically) after start.
  function automatic int pick(input int start, input logic [4:0] cand);
    int best;
    int bd;
    int d;
    best = -1;
    bd = 99;
    for (int i = 0; i < 5; i++) begin
      d = (i - start + 5) % 5;
      if (cand[i] && d < bd) begin
        bd = d;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [4:0] desire_of(input logic [4:0] v, input logic [14:0] a);
    logic [4:0] d;
    for (int i = 0; i < 5; i++) begin
      d[i] = v[i] && (a[i*3 +: 3] == 3'd2) && (i != 2);
    end
    return d;
  endfunction

  initial begin
    int m_owner;
    int m_ptr;
    int old;
    logic [4:0] des;
    logic [4:0] rv;
    logic [14:0] ra;
    logic [4:0] rt;
    logic rr;

    tbl[0]  = '{5'b11011, A2,    5'b11111, 1'b1, 1'b1, 3'd0, 3'd0};
    tbl[1]  = '{5'b11011, A2,    5'b11111, 1'b1, 1'b1, 3'd1, 3'd1};
    tbl[2]  = '{5'b11011, A2,    5'b11111, 1'b1, 1'b1, 3'd3, 3'd2};
    tbl[3]  = '{5'b11011, A2,    5'b11111, 1'b1, 1'b1, 3'd4, 3'd4};
    tbl[4]  = '{5'b11011, A2,    5'b11111, 1'b1, 1'b1, 3'd0, 3'd0};
    tbl[5]  = '{5'b00000, A2,    5'b11111, 1'b1, 1'b1, 3'd0, 3'd0};
    tbl[6]  = '{5'b00001, A2,    5'b00001, 1'b0, 1'b1, 3'd0, 3'd0};
    tbl[7]  = '{5'b00001, A2,    5'b00001, 1'b1, 1'b0, 3'd0, 3'd1};
    tbl[8]  = '{5'b10001, A_MIX, 5'b00000, 1'b1, 1'b1, 3'd0, 3'd1};
    tbl[9]  = '{5'b10001, A_MIX, 5'b00000, 1'b1, 1'b1, 3'd0, 3'd1};
    tbl[10] = '{5'b10001, A_MIX, 5'b10001, 1'b1, 1'b0, 3'd0, 3'd1};
    tbl[11] = '{5'b10000, A_MIX, 5'b10000, 1'b1, 1'b0, 3'd0, 3'd1};
    tbl[12] = '{5'b00100, A2,    5'b00100, 1'b1, 1'b0, 3'd0, 3'd1};

    // Reset state
    reset = 1'b0;
    step();
    check("reset_state", {20'd0, gv, oh, idx, ptr}, pack5(1'b0, 3'd0, 3'd0));
    check("reset_state3", {24'd0, gv3, oh3, idx3, ptr3}, 32'd0);
    reset = 1'b1;

    // Table: rotation 0,1,3,4,0, holds, address mismatch, self index
    for (int n = 0; n < 13; n++) begin
      drive(tbl[n].valid, tbl[n].addr, tbl[n].tail, tbl[n].ready);
      step();
      $display("vec %0d: gv=%0d idx=%0d ptr=%0d", n, gv, idx, ptr);
      check($sformatf("vec%0d", n), {20'd0, gv, oh, idx, ptr},
            pack5(tbl[n].exp_gv, tbl[n].exp_idx, tbl[n].exp_ptr));
    end

    // Lone input 3, held off by out_ready, then tail releases to idle
    do_reset();
    drive(5'b01000, A2, 5'b00000, 1'b1);
    step();
    check("solo3_grant", {20'd0, gv, oh, idx, ptr}, pack5(1'b1, 3'd3, 3'd0));
    for (int n = 0; n < 4; n++) begin
      drive(5'b01000, A2, 5'b01000, 1'b0);
      step();
      check("solo3_hold", {20'd0, gv, oh, idx, ptr}, pack5(1'b1, 3'd3, 3'd0));
    end
    drive(5'b01000, A2, 5'b01000, 1'b1);
    step();
    $display("solo3 release: gv=%0d ptr=%0d", gv, ptr);
    check("solo3_release", {20'd0, gv, oh, idx, ptr}, pack5(1'b0, 3'd0, 3'd4));

    // Input 0 waits behind owner 1, then takes over with no idle cycle
    do_reset();
    drive(5'b00010, A2, 5'b00000, 1'b1);
    step();
    check("own1_grant", {20'd0, gv, oh, idx, ptr}, pack5(1'b1, 3'd1, 3'd0));
    for (int n = 0; n < 2; n++) begin
      drive(5'b00011, A2, 5'b00000, 1'b1);
      step();
      check("own1_body", {20'd0, gv, oh, idx, ptr}, pack5(1'b1, 3'd1, 3'd0));
    end
    drive(5'b00011, A2, 5'b00010, 1'b1);
    step();
    $display("handover: gv=%0d idx=%0d ptr=%0d", gv, idx, ptr);
    check("handover_to0", {20'd0, gv, oh, idx, ptr}, pack5(1'b1, 3'd0, 3'd2));

    // Three-input instance wraps 0,1,2,0
    do_reset();
    v3 = 3'b111; a3 = {3{3'd2}}; t3 = 3'b111; r3 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      logic [1:0] e;
      logic [2:0] eo;
      e = 2'((n) % 3);
      eo = '0;
      eo[e] = 1'b1;
      step();
      $display("n3 pkt %0d: idx=%0d ptr=%0d", n, idx3, ptr3);
      check("n3_wrap", {24'd0, gv3, oh3, idx3, ptr3}, {24'd0, 1'b1, eo, e, e});
    end
    v3 = '0;

    // Asynchronous reset while locked on input 4
    do_reset();
    drive(5'b10000, A2, 5'b00000, 1'b1);
    step();
    check("lock4", {20'd0, gv, oh, idx, ptr}, pack5(1'b1, 3'd4, 3'd0));
    step();
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {20'd0, gv, oh, idx, ptr}, pack5(1'b0, 3'd0, 3'd0));
    drive(5'b11011, A2, 5'b11111, 1'b1);
    step();
    reset = 1'b1;
    step();
    check("restart_from0", {20'd0, gv, oh, idx, ptr}, pack5(1'b1, 3'd0, 3'd0));

    // Random traffic against the packet-level model
    do_reset();
    m_owner = -1;
    m_ptr = 0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) begin
        rv[i] = ($urandom_range(0, 3) != 0);
        ra[i*3 +: 3] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
        rt[i] = ($urandom_range(0, 2) == 0);
      end
      rr = ($urandom_range(0, 3) != 0);
      drive(rv, ra, rt, rr);
      des = desire_of(rv, ra);
      if (m_owner < 0) begin
        m_owner = pick(m_ptr, des);
      end else if (rv[m_owner] && rr && rt[m_owner]) begin
        old = m_owner;
        m_ptr = (old + 1) % 5;
        des[old] = 1'b0;
        m_owner = pick(m_ptr, des);
      end
      step();
      if (m_owner >= 0 && n % 20 == 0) begin
        $display("rand %0d: owner=%0d ptr=%0d", n, m_owner, m_ptr);
      end
      check("random", {20'd0, gv, oh, idx, ptr},
            pack5(m_owner >= 0, (m_owner >= 0) ? 3'(m_owner) : 3'd0, 3'(m_ptr)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
